// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, 64-bit ALU, NZVC flags,
// branch decision/target, and an integrated EX/MEM pipeline register.
// Ports: clk, async active-high reset, enable (stall), flush (bubble),
//   ID/EX data + control inputs, forwarding selects/data,
//   EX/MEM registered outputs, flags_out {N,Z,V,C}.
// Optional: define EX_EARLY_BRANCH_EN to expose early_taken/early_target
//   (combinational branch outputs for fetch redirect).
module ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        flush,
   input  logic [63:0] reg1_in,
   input  logic [63:0] reg2_in,
   input  logic [63:0] imm_in,
   input  logic [63:0] pc_plus4_in,
   input  logic [4:0]  rd_in,
   input  logic [2:0]  alu_op_in,
   input  logic        alu_src_in,
   input  logic        flag_write_in,
   input  logic        is_cbz_in,
   input  logic        is_blt_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        take_branch_in,
   input  logic        uncond_branch_in,
   input  logic        reg_branch_in,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic        link_write_in,
   input  logic [1:0]  fwd_a_sel,
   input  logic [1:0]  fwd_b_sel,
   input  logic [63:0] mem_fwd_data,
   input  logic [63:0] wb_fwd_data,
   output logic [63:0] alu_result_out,
   output logic [63:0] store_data_out,
   output logic [63:0] branch_target_out,
   output logic [63:0] pc_plus4_out,
   output logic [4:0]  rd_out,
   output logic        branch_taken_out,
   output logic        mem_read_out,
   output logic        mem_write_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        link_write_out,
`ifdef EX_EARLY_BRANCH_EN
   output logic        early_taken,
   output logic [63:0] early_target,
`endif
   output logic [3:0]  flags_out
);

   logic [63:0] fwd_a;
   logic [63:0] fwd_b;
   logic [63:0] alu_b;
   logic [63:0] res;
   logic        c_flag;
   logic        v_flag;
   logic        cbz_cond;
   logic        blt_cond;
   logic        taken;
   logic [63:0] target;

   // select 2'b11 is reserved and falls back to the ID/EX value
   always_comb begin
      fwd_a = reg1_in;
      case (fwd_a_sel)
         2'b01:   fwd_a = mem_fwd_data;
         2'b10:   fwd_a = wb_fwd_data;
         default: fwd_a = reg1_in;
      endcase
   end

   always_comb begin
      fwd_b = reg2_in;
      case (fwd_b_sel)
         2'b01:   fwd_b = mem_fwd_data;
         2'b10:   fwd_b = wb_fwd_data;
         default: fwd_b = reg2_in;
      endcase
   end

   assign alu_b = alu_src_in ? imm_in : fwd_b;

   // subtract is A + ~B + 1 so C is the ARM-style "no borrow" carry
   always_comb begin
      res    = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (alu_op_in)
         3'b000: res = alu_b;
         3'b010: begin
            {c_flag, res} = {1'b0, fwd_a} + {1'b0, alu_b};
            v_flag = (fwd_a[63] == alu_b[63]) & (res[63] != fwd_a[63]);
         end
         3'b011: begin
            {c_flag, res} = {1'b0, fwd_a} + {1'b0, ~alu_b} + 65'd1;
            v_flag = (fwd_a[63] != alu_b[63]) & (res[63] != fwd_a[63]);
         end
         3'b100: res = fwd_a & alu_b;
         3'b101: res = fwd_a | alu_b;
         3'b110: res = fwd_a ^ alu_b;
         default: res = '0;
      endcase
   end

   // blt looks at the registered flags, never this instruction's result
   assign cbz_cond = (fwd_b == 64'd0);
   assign blt_cond = flags_out[3] ^ flags_out[1];

   assign taken = uncond_branch_in | reg_branch_in
                | (take_branch_in & ((is_cbz_in & cbz_cond)
                                   | (is_blt_in & blt_cond)));

   assign target = reg_branch_in ? fwd_a
                 : (pc_plus4_in - 64'd4) + {imm_in[61:0], 2'b00};

`ifdef EX_EARLY_BRANCH_EN
   assign early_taken  = taken;
   assign early_target = target;
`endif

   // flush loads even while stalled so a bubble always lands in EX/MEM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_result_out    <= '0;
         store_data_out    <= '0;
         branch_target_out <= '0;
         pc_plus4_out      <= '0;
         rd_out            <= '0;
         branch_taken_out  <= 1'b0;
         mem_read_out      <= 1'b0;
         mem_write_out     <= 1'b0;
         reg_write_out     <= 1'b0;
         mem_to_reg_out    <= 1'b0;
         link_write_out    <= 1'b0;
         flags_out         <= 4'b0000;
      end else begin
         if (enable | flush) begin
            alu_result_out    <= res;
            store_data_out    <= fwd_b;
            branch_target_out <= target;
            pc_plus4_out      <= pc_plus4_in;
            rd_out            <= rd_in;
            branch_taken_out  <= taken & ~flush;
            mem_read_out      <= mem_read_in & ~flush;
            mem_write_out     <= mem_write_in & ~flush;
            reg_write_out     <= reg_write_in & ~flush;
            mem_to_reg_out    <= mem_to_reg_in & ~flush;
            link_write_out    <= link_write_in & ~flush;
         end
         if (flag_write_in & enable & ~flush)
            flags_out <= {res[63], (res == 64'd0), v_flag, c_flag};
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed table-driven bench for ex_stage plus hand-written
// stall/flush/reset/early-branch sequences.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        flush;
   logic [63:0] reg1_in, reg2_in, imm_in, pc_plus4_in;
   logic [4:0]  rd_in;
   logic [2:0]  alu_op_in;
   logic        alu_src_in, flag_write_in, is_cbz_in, is_blt_in;
   logic        mem_read_in, mem_write_in, take_branch_in;
   logic        uncond_branch_in, reg_branch_in;
   logic        reg_write_in, mem_to_reg_in, link_write_in;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [63:0] mem_fwd_data, wb_fwd_data;
   logic [63:0] alu_result_out, store_data_out;
   logic [63:0] branch_target_out, pc_plus4_out;
   logic [4:0]  rd_out;
   logic        branch_taken_out, mem_read_out, mem_write_out;
   logic        reg_write_out, mem_to_reg_out, link_write_out;
   logic [3:0]  flags_out;
`ifdef EX_EARLY_BRANCH_EN
   logic        early_taken;
   logic [63:0] early_target;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .reg1_in(reg1_in), .reg2_in(reg2_in), .imm_in(imm_in),
      .pc_plus4_in(pc_plus4_in), .rd_in(rd_in), .alu_op_in(alu_op_in),
      .alu_src_in(alu_src_in), .flag_write_in(flag_write_in),
      .is_cbz_in(is_cbz_in), .is_blt_in(is_blt_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .take_branch_in(take_branch_in),
      .uncond_branch_in(uncond_branch_in),
      .reg_branch_in(reg_branch_in), .reg_write_in(reg_write_in),
      .mem_to_reg_in(mem_to_reg_in), .link_write_in(link_write_in),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .branch_target_out(branch_target_out),
      .pc_plus4_out(pc_plus4_out), .rd_out(rd_out),
      .branch_taken_out(branch_taken_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .link_write_out(link_write_out),
`ifdef EX_EARLY_BRANCH_EN
      .early_taken(early_taken), .early_target(early_target),
`endif
      .flags_out(flags_out)
   );

   typedef struct packed {
      logic [63:0] r1, r2, imm, pc4, mfwd, wfwd;
      logic [2:0]  op;
      logic        src, fw, cbz, blt, tb, ub, rb;
      logic [1:0]  fa, fb;
      logic [63:0] e_res, e_st, e_tgt;
      logic        e_tk;
      logic [3:0]  e_fl;
   } vec_t;

   vec_t vq[$];
   vec_t t;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      reg1_in = '0; reg2_in = '0; imm_in = '0; pc_plus4_in = 64'd4;
      rd_in = '0; alu_op_in = '0; alu_src_in = 0; flag_write_in = 0;
      is_cbz_in = 0; is_blt_in = 0; mem_read_in = 0; mem_write_in = 0;
      take_branch_in = 0; uncond_branch_in = 0; reg_branch_in = 0;
      reg_write_in = 0; mem_to_reg_in = 0; link_write_in = 0;
      fwd_a_sel = '0; fwd_b_sel = '0; mem_fwd_data = '0; wb_fwd_data = '0;
   endtask

   function automatic vec_t blank();
      vec_t b;
      b = '0;
      b.pc4 = 64'd4;
      return b;
   endfunction

   initial begin
      idle();
      reset = 1'b1; enable = 1'b1; flush = 1'b0;

      // V0 ADD 5+7
      t = blank(); t.r1 = 5; t.r2 = 7; t.op = 3'b010; t.fw = 1;
      t.e_res = 12; t.e_st = 7; t.e_fl = 4'b0000; vq.push_back(t);
      // V1 SUBS 0x8000.. - imm 1: overflow
      t = blank(); t.r1 = 64'h8000_0000_0000_0000; t.imm = 1; t.src = 1;
      t.op = 3'b011; t.fw = 1; t.e_res = 64'h7FFF_FFFF_FFFF_FFFF;
      t.e_tgt = 4; t.e_fl = 4'b0011; vq.push_back(t);
      // V2 BLT on N^V=1
      t = blank(); t.tb = 1; t.blt = 1; t.pc4 = 64'h40; t.imm = 2;
      t.e_tgt = 64'h44; t.e_tk = 1; t.e_fl = 4'b0011; vq.push_back(t);
      // V3 CBZ with mem forward of zero
      t = blank(); t.r2 = 9; t.fb = 2'b01; t.cbz = 1; t.tb = 1;
      t.pc4 = 64'h104; t.imm = 4; t.e_tgt = 64'h110; t.e_tk = 1;
      t.e_fl = 4'b0011; vq.push_back(t);
      // V4 CBZ not taken, wb forward of 5
      t = blank(); t.fb = 2'b10; t.wfwd = 5; t.cbz = 1; t.tb = 1;
      t.pc4 = 64'h104; t.imm = 4; t.e_res = 5; t.e_st = 5;
      t.e_tgt = 64'h110; t.e_fl = 4'b0011; vq.push_back(t);
      // V5 reserved select behaves as ID/EX
      t = blank(); t.r2 = 3; t.fb = 2'b11; t.mfwd = 64'h99;
      t.wfwd = 64'h77; t.e_res = 3; t.e_st = 3; t.e_fl = 4'b0011;
      vq.push_back(t);
      // V6 SUB equal -> Z,C
      t = blank(); t.r1 = 10; t.r2 = 10; t.op = 3'b011; t.fw = 1;
      t.e_st = 10; t.e_fl = 4'b0101; vq.push_back(t);
      // V7 SUB 1-2 -> N, borrow
      t = blank(); t.r1 = 1; t.r2 = 2; t.op = 3'b011; t.fw = 1;
      t.e_res = '1; t.e_st = 2; t.e_fl = 4'b1000; vq.push_back(t);
      // V8 BLT on N=1
      t = blank(); t.tb = 1; t.blt = 1; t.e_tk = 1; t.e_fl = 4'b1000;
      vq.push_back(t);
      // V9 ADD carry wrap
      t = blank(); t.r1 = '1; t.imm = 1; t.src = 1; t.op = 3'b010;
      t.fw = 1; t.e_tgt = 4; t.e_fl = 4'b0101; vq.push_back(t);
      // V10 BLT with flag write: uses old flags (not taken)
      t = blank(); t.r1 = 1; t.r2 = 2; t.op = 3'b011; t.fw = 1;
      t.tb = 1; t.blt = 1; t.e_res = '1; t.e_st = 2; t.e_fl = 4'b1000;
      vq.push_back(t);
      // V11 AND
      t = blank(); t.r1 = 64'hF0; t.r2 = 64'h3C; t.op = 3'b100;
      t.fw = 1; t.e_res = 64'h30; t.e_st = 64'h3C; t.e_fl = 4'b0000;
      vq.push_back(t);
      // V12 OR, no flag write
      t = blank(); t.r1 = 64'hF0; t.r2 = 64'h0C; t.op = 3'b101;
      t.e_res = 64'hFC; t.e_st = 64'h0C; t.e_fl = 4'b0000;
      vq.push_back(t);
      // V13 unconditional B, negative offset
      t = blank(); t.ub = 1; t.pc4 = 64'h20; t.imm = '1 - 64'd1;
      t.e_tgt = 64'h14; t.e_tk = 1; vq.push_back(t);
      // V14 register branch via forwarded A
      t = blank(); t.rb = 1; t.r1 = 64'h55; t.fa = 2'b01;
      t.mfwd = 64'h1234; t.e_tgt = 64'h1234; t.e_tk = 1;
      vq.push_back(t);
      // V15 ADD positive overflow
      t = blank(); t.r1 = 64'h7FFF_FFFF_FFFF_FFFF; t.r2 = 1;
      t.op = 3'b010; t.fw = 1; t.e_res = 64'h8000_0000_0000_0000;
      t.e_st = 1; t.e_fl = 4'b1010; vq.push_back(t);
      // V16 wb forward on A, immediate B
      t = blank(); t.r1 = 1; t.fa = 2'b10; t.wfwd = 100; t.imm = 23;
      t.src = 1; t.op = 3'b010; t.e_res = 123; t.e_tgt = 64'h5C;
      t.e_fl = 4'b1010; vq.push_back(t);

      #12;
      chk("rst_res", alu_result_out, 0);
      chk("rst_flags", {60'd0, flags_out}, 0);
      chk("rst_ctrl", {58'd0, branch_taken_out, mem_read_out,
          mem_write_out, reg_write_out, mem_to_reg_out,
          link_write_out}, 0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         idle();
         reg1_in = vq[i].r1; reg2_in = vq[i].r2; imm_in = vq[i].imm;
         pc_plus4_in = vq[i].pc4; mem_fwd_data = vq[i].mfwd;
         wb_fwd_data = vq[i].wfwd; alu_op_in = vq[i].op;
         alu_src_in = vq[i].src; flag_write_in = vq[i].fw;
         is_cbz_in = vq[i].cbz; is_blt_in = vq[i].blt;
         take_branch_in = vq[i].tb; uncond_branch_in = vq[i].ub;
         reg_branch_in = vq[i].rb; fwd_a_sel = vq[i].fa;
         fwd_b_sel = vq[i].fb; reg_write_in = 1;
         @(posedge clk); #1;
         chk($sformatf("v%0d_res", i), alu_result_out, vq[i].e_res);
         chk($sformatf("v%0d_st", i), store_data_out, vq[i].e_st);
         chk($sformatf("v%0d_tgt", i), branch_target_out, vq[i].e_tgt);
         chk($sformatf("v%0d_tk", i), {63'd0, branch_taken_out},
             {63'd0, vq[i].e_tk});
         chk($sformatf("v%0d_fl", i), {60'd0, flags_out},
             {60'd0, vq[i].e_fl});
         chk($sformatf("v%0d_pc4", i), pc_plus4_out, vq[i].pc4);
         chk($sformatf("v%0d_rw", i), {63'd0, reg_write_out}, 64'd1);
      end

      // full-control capture then stall
      @(negedge clk);
      idle();
      reg1_in = 64'hAA; reg2_in = 64'h55; alu_op_in = 3'b110;
      flag_write_in = 1; uncond_branch_in = 1; rd_in = 5'd17;
      mem_read_in = 1; mem_write_in = 1; mem_to_reg_in = 1;
      link_write_in = 1; reg_write_in = 1;
      @(posedge clk); #1;
      chk("cap_res", alu_result_out, 64'hFF);
      chk("cap_rd", {59'd0, rd_out}, 64'd17);
      chk("cap_ctrl", {58'd0, branch_taken_out, mem_read_out,
          mem_write_out, reg_write_out, mem_to_reg_out,
          link_write_out}, 64'h3F);
      chk("cap_fl", {60'd0, flags_out}, 0);

      @(negedge clk);
      idle();
      enable = 0; reg1_in = 1; reg2_in = 2; alu_op_in = 3'b011;
      flag_write_in = 1; rd_in = 5'd3;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d_res", k), alu_result_out, 64'hFF);
         chk($sformatf("stall%0d_fl", k), {60'd0, flags_out}, 0);
         chk($sformatf("stall%0d_rd", k), {59'd0, rd_out}, 64'd17);
         chk($sformatf("stall%0d_ctrl", k), {58'd0, branch_taken_out,
             mem_read_out, mem_write_out, reg_write_out,
             mem_to_reg_out, link_write_out}, 64'h3F);
      end

      // flush while stalled still bubbles; flags untouched
      @(negedge clk);
      flush = 1; reg_write_in = 1; mem_read_in = 1; uncond_branch_in = 1;
      @(posedge clk); #1;
      chk("flush_ctrl", {58'd0, branch_taken_out, mem_read_out,
          mem_write_out, reg_write_out, mem_to_reg_out,
          link_write_out}, 0);
      chk("flush_fl", {60'd0, flags_out}, 0);

      // set flags, then reset asynchronously mid-stall
      @(negedge clk);
      idle();
      flush = 0; enable = 1; reg1_in = 1; reg2_in = 2;
      alu_op_in = 3'b011; flag_write_in = 1; reg_write_in = 1;
      pc_plus4_in = 64'h80;
      @(posedge clk); #1;
      chk("pre_rst_fl", {60'd0, flags_out}, 64'h8);
      chk("pre_rst_res", alu_result_out, '1);
      #2;
      enable = 0;
      reset = 1;
      #1;
      chk("arst_res", alu_result_out, 0);
      chk("arst_fl", {60'd0, flags_out}, 0);
      chk("arst_pc4", pc_plus4_out, 0);
      chk("arst_rw", {63'd0, reg_write_out}, 0);
      @(negedge clk);
      reset = 0;
      idle();
      enable = 1; reg1_in = 64'hF0; reg2_in = 64'hFF;
      alu_op_in = 3'b110;
      @(posedge clk); #1;
      chk("xor_res", alu_result_out, 64'h0F);

`ifdef EX_EARLY_BRANCH_EN
      @(negedge clk);
      idle();
      uncond_branch_in = 1; imm_in = '1 - 64'd1; pc_plus4_in = 64'h20;
      #1;
      chk("early_tk", {63'd0, early_taken}, 64'd1);
      chk("early_tgt", early_target, 64'h14);
      idle();
      is_cbz_in = 1; take_branch_in = 1; reg2_in = 64'd1;
      #1;
      chk("early_nt", {63'd0, early_taken}, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
